// File: rtl/mux_skid_pkg.sv
// Shared types and defaults for the inverting skid buffer.
// The state enum is common to the buffer and anything that observes its occupancy.
package mux_skid_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    localparam int WIDTH_DEF = 8;
    localparam int CNT_W_DEF = 16;

endpackage

// File: rtl/mux_inverter_skid_buffer_mux2.sv
// Single-bit 2:1 multiplexer; the inverting buffer uses one of these per data bit.
module Mux2 (
    input  logic d0,
    input  logic d1,
    input  logic sel,
    output logic y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux_inverter_skid_buffer.sv
// Two-entry skid buffer that optionally inverts each word as it is accepted.
// up_ready depends only on registered state, so there is no ready path from downstream to upstream.
module mux_inverter_skid_buffer
    import mux_skid_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             inv_en,
    output logic             up_ready,
    output logic             down_valid,
    output logic [WIDTH-1:0] down_data,
    input  logic             down_ready,
    output logic [CNT_W-1:0] xfer_count
);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   mainData_q, mainData_d;
    logic [WIDTH-1:0]   skidData_q, skidData_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   muxWord;
    logic               accept;
    logic               drain;

    // inv_en only matters at the edge that captures the word, so no copy of it is stored.
    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        Mux2 u_mux (
            .d0  (up_data[b]),
            .d1  (~up_data[b]),
            .sel (inv_en),
            .y   (muxWord[b])
        );
    end

    assign up_ready   = (state_q != FULL);
    assign down_valid = (state_q != EMPTY);
    assign down_data  = mainData_q;
    assign xfer_count = count_q;

    assign accept = up_valid && up_ready;
    assign drain  = down_valid && down_ready;

    always_comb begin
        state_d    = state_q;
        mainData_d = mainData_q;
        skidData_d = skidData_q;
        count_d    = drain ? count_q + CNT_W'(1) : count_q;

        case (state_q)
            EMPTY: begin
                if (accept) begin
                    mainData_d = muxWord;
                    state_d    = ONE;
                end
            end
            ONE: begin
                if (accept && !drain) begin
                    skidData_d = muxWord;
                    state_d    = FULL;
                end else if (drain && !accept) begin
                    state_d    = EMPTY;
                end else if (accept && drain) begin
                    mainData_d = muxWord;
                end
            end
            FULL: begin
                // up_ready is low here, so only the downstream side can move data.
                if (drain) begin
                    mainData_d = skidData_q;
                    state_d    = ONE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= EMPTY;
            mainData_q <= '0;
            skidData_q <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            mainData_q <= mainData_d;
            skidData_q <= skidData_d;
            count_q    <= count_d;
        end
    end

endmodule
